keypad_mmio: RTL and testbench

// - Memory-mapped 4x4 keypad responder on the CPU data bus (address / write data / wen / read data).
// - Scans the keypad columns, synchronises and debounces the rows, and latches one key code.
// - Presents the latched code in a status register that the CPU polls with loads and clears with a store.
// - Sits beside the RAM and hex-display decode inside the integrated memory block; keypad pins go to GPIO_1.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_row_sync.sv | 42 ++++
 rtl/keypad_mmio.sv | 149 ++++++++++++++
 tb/tb_keypad_mmio.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the memory-mapped 4x4 keypad responder:
// register offsets, KEY register bit positions and the scan state encoding.
package keypad_pkg;

    localparam logic [31:0] KEY_OFS  = 32'd0;
    localparam logic [31:0] CTRL_OFS = 32'd4;

    localparam int VALID_BIT   = 4;
    localparam int OVR_BIT     = 5;
    localparam int PRESSED_BIT = 6;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        CHECK    = 2'd1,
        DEBOUNCE = 2'd2,
        HELD     = 2'd3
    } scan_state_t;

    // Index of the lowest active-low row in a captured pattern.
    function automatic logic [1:0] low_row_idx(input logic [3:0] pat);
        if (!pat[0])      return 2'd0;
        else if (!pat[1]) return 2'd1;
        else if (!pat[2]) return 2'd2;
        else              return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop row synchroniser plus a stability counter that pulses stable_done
// once the synchronised rows have matched the target for DEBOUNCE_CYCLES cycles.
module keypad_row_sync #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    input  logic [3:0] target,
    input  logic       enable,
    output logic [3:0] rows_s,
    output logic       stable_done
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       rows_m;
    logic [CNT_W-1:0] stable_cnt;
    logic             match;

    assign match       = enable && (rows_s == target);
    assign stable_done = match && (stable_cnt == STABLE_LAST);

    // NOTE: non-blocking assignments make both stages sample on the same edge,
    // so rows_s really is two flops behind the pins rather than one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_m     <= 4'hF;
            rows_s     <= 4'hF;
            stable_cnt <= '0;
        end else begin
            rows_m <= rows;
            rows_s <= rows_m;
            if (!match || stable_done)
                stable_cnt <= '0;
            else if (stable_cnt != STABLE_LAST)
                stable_cnt <= stable_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_mmio.sv
// Keypad responder on the CPU data bus: column scan FSM, key latch,
// KEY/CTRL register bank and full 32-bit address decode.
module keypad_mmio
    import keypad_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0010,
    parameter int          SETTLE_CYCLES   = 16,
    parameter int          DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        wen,
    output logic [31:0] data_out,
    output logic        hit,
    output logic [3:0]  cols,
    input  logic [3:0]  rows
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [31:0] KEY_ADDR  = BASE_ADDR + KEY_OFS;
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFS;

    scan_state_t      state, state_next;
    logic [1:0]       col_idx, col_next;
    logic [3:0]       pat, pat_next;
    logic [CNT_W-1:0] settle_cnt, settle_next;
    logic [3:0]       code;
    logic             valid, ovr;
    logic             latch;

    logic [3:0] rows_s;
    logic       stable_done;
    logic [3:0] sync_target;
    logic       sync_enable;

    assign sync_target = (state == HELD) ? 4'hF : pat;
    assign sync_enable = (state == DEBOUNCE) || (state == HELD);

    keypad_row_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_row_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rows       (rows),
        .target     (sync_target),
        .enable     (sync_enable),
        .rows_s     (rows_s),
        .stable_done(stable_done)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        col_next    = col_idx;
        pat_next    = pat;
        settle_next = '0;
        latch       = 1'b0;
        case (state)
            SCAN: begin
                if (settle_cnt == SETTLE_LAST) state_next = CHECK;
                else                           settle_next = settle_cnt + 1'b1;
            end
            CHECK: begin
                if (rows_s == 4'hF) begin
                    col_next   = col_idx + 2'd1;
                    state_next = SCAN;
                end else begin
                    pat_next   = rows_s;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // A changed pattern rescans the same column from a fresh settle.
                if (rows_s != pat) begin
                    state_next = SCAN;
                end else if (stable_done) begin
                    latch      = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (stable_done) begin
                    col_next   = col_idx + 2'd1;
                    state_next = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCAN;
            col_idx    <= 2'd0;
            pat        <= 4'hF;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            col_idx    <= col_next;
            pat        <= pat_next;
            settle_cnt <= settle_next;
        end
    end

    logic key_sel, ctrl_sel, clear;
    logic unused_data;

    assign key_sel     = (address == KEY_ADDR);
    assign ctrl_sel    = (address == CTRL_ADDR);
    assign clear       = wen && ctrl_sel && data_in[0];
    assign unused_data = ^data_in[31:1];

    // A latch in the same cycle as a clear wins, leaving ovr cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code  <= 4'h0;
            valid <= 1'b0;
            ovr   <= 1'b0;
        end else if (latch) begin
            code  <= {low_row_idx(pat), col_idx};
            valid <= 1'b1;
            ovr   <= clear ? 1'b0 : (ovr | valid);
        end else if (clear) begin
            valid <= 1'b0;
            ovr   <= 1'b0;
        end
    end

    logic [31:0] key_word;

    always_comb begin
        key_word              = '0;
        key_word[3:0]         = code;
        key_word[VALID_BIT]   = valid;
        key_word[OVR_BIT]     = ovr;
        key_word[PRESSED_BIT] = (state == HELD);
    end

    assign data_out = key_sel ? key_word : 32'h0;
    assign hit      = key_sel || ctrl_sel;
    assign cols     = ~(4'b0001 << col_idx);

endmodule

// File: tb/tb_keypad_mmio.sv
// Self-checking bench for keypad_mmio with a keypad model and a read scoreboard.
module tb_keypad_mmio;

    localparam logic [31:0] BASE = 32'hFFFF_0010;
    localparam logic [31:0] CTRL = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        wen;
    logic [31:0] data_out;
    logic        hit;
    logic [3:0]  cols;
    logic [3:0]  rows;

    logic       key_down;
    logic [1:0] key_row, key_col;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    // Keypad model: the pressed key pulls its row low only while its column is driven.
    assign rows = (key_down && (cols == ~(4'b0001 << key_col))) ? ~(4'b0001 << key_row) : 4'hF;

    keypad_mmio #(
        .BASE_ADDR      (BASE),
        .SETTLE_CYCLES  (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .data_in (data_in),
        .wen     (wen),
        .data_out(data_out),
        .hit     (hit),
        .cols    (cols),
        .rows    (rows)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_hit);
        exp_t e;
        string t;
        address = addr;
        wen     = 1'b0;
        exp_q.push_back('{exp_data, exp_hit});
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, data_out, e.data);
        check({t, "_hit"}, {31'd0, hit}, {31'd0, e.hit});
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        address = addr;
        data_in = data;
        wen     = 1'b1;
        @(negedge clk);
        wen     = 1'b0;
        data_in = 32'h0;
        address = 32'h0;
    endtask

    // Returns at the first negedge after cols switches to target.
    task automatic wait_cols(input string tag, input logic [3:0] target);
        int n = 0;
        while (cols == target && n < 40) begin @(negedge clk); n++; end
        while (cols != target && n < 40) begin @(negedge clk); n++; end
        check({tag, "_wait"}, {28'd0, cols}, {28'd0, target});
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_row  = r;
        key_col  = c;
        key_down = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [3:0] idle_seq [4];
        logic [3:0] prev;
        int n;

        idle_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n = 1'b0; address = 32'h0; data_in = 32'h0; wen = 1'b0;
        key_down = 1'b0; key_row = 2'd0; key_col = 2'd0;

        tick(3);
        check("rst_cols", {28'd0, cols}, 32'h0000_000E);
        bus_read("rst_key", BASE, 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan: each column is driven for SETTLE+1 = 3 cycles.
        prev = cols;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (cols == prev && n < 20) begin @(negedge clk); n++; end
            check("idle_col", {28'd0, cols}, {28'd0, idle_seq[i]});
            check("idle_dwell", n, 32'd3);
            prev = cols;
        end
        bus_read("idle_key", BASE, 32'h0, 1'b1);

        // Single press row2/col1 -> code 9.
        press(2'd2, 2'd1);
        tick(40);
        bus_read("press_held", BASE, 32'h0000_0059, 1'b1);
        key_down = 1'b0;
        tick(5);
        bus_read("release_early", BASE, 32'h0000_0059, 1'b1);
        tick(10);
        bus_read("release_done", BASE, 32'h0000_0019, 1'b1);
        bus_write(CTRL, 32'h1);
        bus_read("clear1", BASE, 32'h0000_0009, 1'b1);

        // Bouncing contact on row0/col0, then a solid hold.
        key_row = 2'd0; key_col = 2'd0;
        for (int i = 0; i < 10; i++) begin
            key_down = ~key_down;
            tick(3);
        end
        key_down = 1'b1;
        tick(40);
        bus_read("bounce_held", BASE, 32'h0000_0050, 1'b1);
        key_down = 1'b0;
        tick(15);
        bus_read("bounce_rel", BASE, 32'h0000_0010, 1'b1);
        bus_write(CTRL, 32'h1);
        bus_read("clear2", BASE, 32'h0000_0000, 1'b1);

        // Overflow: key 3 then key 6 without clearing.
        press(2'd0, 2'd3);
        tick(40);
        bus_read("key3_held", BASE, 32'h0000_0053, 1'b1);
        key_down = 1'b0;
        tick(15);
        bus_read("key3_rel", BASE, 32'h0000_0013, 1'b1);
        press(2'd1, 2'd2);
        tick(40);
        bus_read("key6_held", BASE, 32'h0000_0076, 1'b1);
        key_down = 1'b0;
        tick(15);
        bus_read("ovr_set", BASE, 32'h0000_0036, 1'b1);
        bus_write(CTRL, 32'h2);
        bus_read("ctrl_bit1", BASE, 32'h0000_0036, 1'b1);
        bus_write(CTRL, 32'h1);
        bus_read("ovr_clear", BASE, 32'h0000_0006, 1'b1);

        // Collision: valid already set, clear lands on the latch edge of key C.
        press(2'd0, 2'd2);
        tick(40);
        key_down = 1'b0;
        tick(15);
        bus_read("pre_coll", BASE, 32'h0000_0012, 1'b1);
        wait_cols("coll_col1", 4'b1101);
        press(2'd3, 2'd0);
        wait_cols("coll_col0", 4'b1110);
        // Col0 driven at edge T0; settle 2, check 1, debounce 8 -> latch at T0+11.
        tick(10);
        bus_write(CTRL, 32'h1);
        bus_read("collision", BASE, 32'h0000_005C, 1'b1);
        key_down = 1'b0;
        tick(15);
        bus_read("coll_rel", BASE, 32'h0000_001C, 1'b1);

        // Decode.
        bus_read("other_addr", BASE + 32'd8, 32'h0, 1'b0);
        bus_read("ctrl_read", CTRL, 32'h0, 1'b1);
        bus_write(BASE, 32'hFFFF_FFFF);
        bus_write(BASE + 32'd8, 32'h1);
        bus_read("key_wr_ignored", BASE, 32'h0000_001C, 1'b1);

        // Reset in the middle of DEBOUNCE on column 1.
        wait_cols("rst_sync", 4'b1110);
        press(2'd1, 2'd1);
        wait_cols("rst_col1", 4'b1101);
        tick(5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cols", {28'd0, cols}, 32'h0000_000E);
        bus_read("rst_mid_key", BASE, 32'h0, 1'b1);
        @(negedge clk);
        key_down = 1'b0;
        rst_n    = 1'b1;
        tick(40);
        bus_read("post_rst", BASE, 32'h0, 1'b1);

        check("sb_drain", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
